// File: rtl/sparse_weight_encoder_pkg.sv
// swe_pkg: shared widths and state encoding for the sparse weight encoder.
// Provides fallback values for the header.h width macros when that header is absent.
`default_nettype none

`ifndef IA_CHANNEL
`define IA_CHANNEL 4
`endif
`ifndef W_C_LENGTH
`define W_C_LENGTH 16
`endif

package swe_pkg;
  localparam int PTR_W = 11;
  localparam int POS_W = 3;
  localparam int R_W   = 3;
  localparam int K_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

`default_nettype wire

// File: rtl/sparse_weight_encoder_if.sv
// sparse_weight_encoder_if: dense input stream plus sparse result bus.
// Macro SWE_THRESH_PRUNE_EN adds the i_thresh input.
`default_nettype none

interface sparse_weight_encoder_if
  import swe_pkg::*;
#(
  parameter int NGROUP = `IA_CHANNEL * 3,
  parameter int GLEN   = 5,
  parameter int VAL_W  = 8,
  parameter int CAP    = `W_C_LENGTH
);
  logic             i_start;
  logic             i_valid;
  logic [VAL_W-1:0] i_data;
`ifdef SWE_THRESH_PRUNE_EN
  logic [VAL_W-2:0] i_thresh;
`endif
  logic             o_ready;
  logic [PTR_W-1:0] o_ptr [0:NGROUP-1];
  logic [R_W-1:0]   o_r   [0:NGROUP-1];
  logic [K_W-1:0]   o_k   [0:NGROUP-1];
  logic [VAL_W-1:0] o_val [0:CAP-1];
  logic [POS_W-1:0] o_pos [0:CAP-1];
  logic [PTR_W-1:0] o_length;
  logic             o_overflow;
  logic             o_finish;

`ifdef SWE_THRESH_PRUNE_EN
  modport master (
    output i_start, i_valid, i_data, i_thresh,
    input  o_ready, o_ptr, o_r, o_k, o_val, o_pos, o_length, o_overflow, o_finish
  );
  modport slave (
    input  i_start, i_valid, i_data, i_thresh,
    output o_ready, o_ptr, o_r, o_k, o_val, o_pos, o_length, o_overflow, o_finish
  );
`else
  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_ptr, o_r, o_k, o_val, o_pos, o_length, o_overflow, o_finish
  );
  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_ptr, o_r, o_k, o_val, o_pos, o_length, o_overflow, o_finish
  );
`endif
endinterface

`default_nettype wire

// File: rtl/sparse_weight_encoder_nz_detect.sv
// swe_nz_detect: combinational "counts as nonzero" test for one weight.
// Macro SWE_THRESH_PRUNE_EN switches from exact-zero to magnitude-threshold pruning.
`default_nettype none

module swe_nz_detect #(
  parameter int VAL_W = 8
) (
  input  logic [VAL_W-1:0] data_i,
`ifdef SWE_THRESH_PRUNE_EN
  input  logic [VAL_W-2:0] thresh_i,
`endif
  output logic             nz_o
);
`ifdef SWE_THRESH_PRUNE_EN
  logic [VAL_W-1:0] mag;

  // Unsigned magnitude: the most negative value maps to 2^(VAL_W-1) without overflow.
  assign mag  = data_i[VAL_W-1] ? (~data_i + VAL_W'(1)) : data_i;
  assign nz_o = (data_i != '0) && (mag >= {1'b0, thresh_i});
`else
  assign nz_o = |data_i;
`endif
endmodule

`default_nettype wire

// File: rtl/sparse_weight_encoder.sv
// sparse_weight_encoder: dense weight stream -> cumulative group pointers plus packed nonzero list.
// Macro SWE_THRESH_PRUNE_EN enables threshold pruning (i_thresh on the interface).
`default_nettype none

module sparse_weight_encoder
  import swe_pkg::*;
#(
  parameter int NGROUP = `IA_CHANNEL * 3,
  parameter int GLEN   = 5,
  parameter int VAL_W  = 8,
  parameter int CAP    = `W_C_LENGTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  sparse_weight_encoder_if.slave bus
);
  localparam int               GC_W      = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam logic [POS_W-1:0] ELEM_LAST = POS_W'(GLEN - 1);
  localparam logic [GC_W-1:0]  GRP_LAST  = GC_W'(NGROUP - 1);
  localparam logic [PTR_W-1:0] CAP_L     = PTR_W'(CAP);

  state_e           state_q, state_d;
  logic [POS_W-1:0] elem_q, elem_d;
  logic [GC_W-1:0]  grp_q, grp_d;
  logic [PTR_W-1:0] len_q, len_d, len_upd;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] ptr_q [NGROUP];
  logic [PTR_W-1:0] ptr_d [NGROUP];
  logic [VAL_W-1:0] val_q [CAP];
  logic [VAL_W-1:0] val_d [CAP];
  logic [POS_W-1:0] pos_q [CAP];
  logic [POS_W-1:0] pos_d [CAP];
  logic             nz;
  logic             beat;
`ifdef SWE_THRESH_PRUNE_EN
  logic [VAL_W-2:0] thresh_q, thresh_d;
`endif

  swe_nz_detect #(.VAL_W(VAL_W)) u_nz_detect (
    .data_i   (bus.i_data),
`ifdef SWE_THRESH_PRUNE_EN
    .thresh_i (thresh_q),
`endif
    .nz_o     (nz)
  );

  assign beat = (state_q == RECV) && bus.i_valid;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    grp_d   = grp_q;
    len_d   = len_q;
    len_upd = len_q;
    ovf_d   = ovf_q;
    ptr_d   = ptr_q;
    val_d   = val_q;
    pos_d   = pos_q;
`ifdef SWE_THRESH_PRUNE_EN
    thresh_d = thresh_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = RECV;
          elem_d  = '0;
          grp_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
`ifdef SWE_THRESH_PRUNE_EN
          thresh_d = bus.i_thresh;
`endif
        end
      end
      RECV: begin
        if (beat) begin
          if (nz) begin
            if (len_q < CAP_L) begin
              for (int i = 0; i < CAP; i++) begin
                if (len_q == PTR_W'(i)) begin
                  val_d[i] = bus.i_data;
                  pos_d[i] = elem_q;
                end
              end
              len_upd = len_q + PTR_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          len_d = len_upd;
          // Group pointer includes the current beat, so it is taken from the updated length.
          if (elem_q == ELEM_LAST) begin
            elem_d = '0;
            for (int g = 0; g < NGROUP; g++) begin
              if (grp_q == GC_W'(g)) begin
                ptr_d[g] = len_upd;
              end
            end
            if (grp_q == GRP_LAST) begin
              grp_d   = '0;
              state_d = DONE;
            end else begin
              grp_d = grp_q + GC_W'(1);
            end
          end else begin
            elem_d = elem_q + POS_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      grp_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef SWE_THRESH_PRUNE_EN
      thresh_q <= '0;
`endif
      for (int g = 0; g < NGROUP; g++) begin
        ptr_q[g] <= '0;
      end
      for (int i = 0; i < CAP; i++) begin
        val_q[i] <= '0;
        pos_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      grp_q   <= grp_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
`ifdef SWE_THRESH_PRUNE_EN
      thresh_q <= thresh_d;
`endif
      for (int g = 0; g < NGROUP; g++) begin
        ptr_q[g] <= ptr_d[g];
      end
      for (int i = 0; i < CAP; i++) begin
        val_q[i] <= val_d[i];
        pos_q[i] <= pos_d[i];
      end
    end
  end

  assign bus.o_ready    = (state_q == RECV);
  assign bus.o_finish   = (state_q == DONE);
  assign bus.o_length   = len_q;
  assign bus.o_overflow = ovf_q;

  // Row/channel tags are fixed by group index and bypass reset.
  for (genvar g = 0; g < NGROUP; g++) begin : g_grp
    assign bus.o_ptr[g] = ptr_q[g];
    assign bus.o_r[g]   = R_W'(g % 3);
    assign bus.o_k[g]   = K_W'(g / 3);
  end

  for (genvar i = 0; i < CAP; i++) begin : g_list
    assign bus.o_val[i] = val_q[i];
    assign bus.o_pos[i] = pos_q[i];
  end
endmodule

`default_nettype wire

// File: tb/tb_sparse_weight_encoder.sv
// tb_sparse_weight_encoder: table-driven encodes with a model scoreboard,
// plus hand-written reset-abort, saturation and threshold sequences.
`default_nettype none

module tb_sparse_weight_encoder;
  localparam int NG = 12;
  localparam int GL = 5;
  localparam int VW = 8;
  localparam int CP = 16;
  localparam int NB = NG * GL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sparse_weight_encoder_if #(.NGROUP(NG), .GLEN(GL), .VAL_W(VW), .CAP(CP)) bus ();

  sparse_weight_encoder #(.NGROUP(NG), .GLEN(GL), .VAL_W(VW), .CAP(CP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int len;
    int ovf;
    int ptr [NG];
    int val [CP];
    int pos [CP];
  } exp_t;

  typedef struct {
    int kind;
    bit gaps;
    bit noise;
    int exp_len;
    int exp_ovf;
  } vec_t;

  exp_t         sb [$];
  vec_t         tbl [5];
  logic [VW-1:0] stream [NB];
  int           checks   = 0;
  int           failures = 0;
  int           thr      = 0;

  task automatic chk(input string name, input integer act, input integer exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic build(input int kind);
    for (int i = 0; i < NB; i++) stream[i] = '0;
    case (kind)
      1: begin
        stream[1]  = 8'd3;
        stream[4]  = 8'hFE;
        stream[25] = 8'd7;
      end
      2: for (int i = 0; i < NB; i++) stream[i] = 8'd1;
      3: for (int i = 0; i < NB; i++)
           stream[i] = ($urandom_range(0, 2) == 0) ? VW'($urandom_range(1, 255)) : '0;
      4: begin
        stream[0] = 8'd2;
        stream[1] = 8'hFD;
        stream[2] = 8'h80;
        stream[3] = 8'd0;
        stream[4] = 8'd1;
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model();
    exp_t e;
    e.len = 0;
    e.ovf = 0;
    for (int i = 0; i < CP; i++) begin
      e.val[i] = 0;
      e.pos[i] = 0;
    end
    for (int g = 0; g < NG; g++) begin
      for (int p = 0; p < GL; p++) begin
        int s;
        int mag;
        s   = $signed(stream[g*GL+p]);
        mag = (s < 0) ? -s : s;
        if (s != 0 && mag >= thr) begin
          if (e.len < CP) begin
            e.val[e.len] = int'(stream[g*GL+p]);
            e.pos[e.len] = p;
            e.len++;
          end else begin
            e.ovf = 1;
          end
        end
      end
      e.ptr[g] = e.len;
    end
    return e;
  endfunction

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    chk("ready_after_start", bus.o_ready, 1);
  endtask

  task automatic drive(input bit gaps, input bit noise, input int stop_at);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    while (idx < stop_at && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      bus.i_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_data  = stream[idx];
      bus.i_start = noise ? ($urandom_range(0, 4) == 0) : 1'b0;
      @(negedge clk);
      if (bus.i_valid && bus.o_ready) idx++;
    end
    if (guard >= 4000) chk("drive_budget", idx, stop_at);
  endtask

  task automatic finish_check();
    exp_t e;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_start = 1'b1;
    chk("finish_pulse", bus.o_finish, 1);
    chk("ready_low_done", bus.o_ready, 0);
    chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("length", bus.o_length, e.len);
      chk("overflow", bus.o_overflow, e.ovf);
      for (int g = 0; g < NG; g++) chk($sformatf("ptr[%0d]", g), bus.o_ptr[g], e.ptr[g]);
      for (int i = 0; i < e.len; i++) begin
        chk($sformatf("val[%0d]", i), bus.o_val[i], e.val[i]);
        chk($sformatf("pos[%0d]", i), bus.o_pos[i], e.pos[i]);
      end
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      chk("finish_one_cycle", bus.o_finish, 0);
      chk("idle_after_done", bus.o_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("hold_length", bus.o_length, e.len);
    end else begin
      bus.i_start = 1'b0;
    end
  endtask

  task automatic encode(input bit gaps, input bit noise);
    sb.push_back(model());
    start_pulse();
    drive(gaps, noise, NB);
    finish_check();
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
`ifdef SWE_THRESH_PRUNE_EN
    bus.i_thresh = '0;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_finish", bus.o_finish, 0);
    chk("rst_length", bus.o_length, 0);
    chk("rst_overflow", bus.o_overflow, 0);
    for (int g = 0; g < NG; g++) begin
      chk($sformatf("rst_ptr[%0d]", g), bus.o_ptr[g], 0);
      chk($sformatf("r[%0d]", g), bus.o_r[g], g % 3);
      chk($sformatf("k[%0d]", g), bus.o_k[g], g / 3);
    end
    rst_n = 1'b1;

    tbl[0] = '{kind: 0, gaps: 1'b0, noise: 1'b0, exp_len: 0,  exp_ovf: 0};
    tbl[1] = '{kind: 1, gaps: 1'b0, noise: 1'b0, exp_len: 3,  exp_ovf: 0};
    tbl[2] = '{kind: 2, gaps: 1'b0, noise: 1'b0, exp_len: 16, exp_ovf: 1};
    tbl[3] = '{kind: 3, gaps: 1'b1, noise: 1'b1, exp_len: -1, exp_ovf: -1};
    tbl[4] = '{kind: 1, gaps: 1'b1, noise: 1'b1, exp_len: 3,  exp_ovf: 0};

    for (int t = 0; t < 5; t++) begin
      build(tbl[t].kind);
      encode(tbl[t].gaps, tbl[t].noise);
      if (tbl[t].exp_len >= 0) begin
        chk($sformatf("tbl%0d_len", t), bus.o_length, tbl[t].exp_len);
        chk($sformatf("tbl%0d_ovf", t), bus.o_overflow, tbl[t].exp_ovf);
      end
    end

    // Abort an all-ones encode after 30 beats, then encode the sparse stream afresh.
    build(2);
    start_pulse();
    drive(1'b0, 1'b0, 30);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    #2;
    chk("abort_ready", bus.o_ready, 0);
    chk("abort_length", bus.o_length, 0);
    chk("abort_ptr0", bus.o_ptr[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    build(1);
    encode(1'b0, 1'b0);
    chk("sparse_len", bus.o_length, 3);
    chk("sparse_ovf", bus.o_overflow, 0);
    chk("sparse_val0", bus.o_val[0], 3);
    chk("sparse_val1", bus.o_val[1], 254);
    chk("sparse_val2", bus.o_val[2], 7);
    chk("sparse_pos0", bus.o_pos[0], 1);
    chk("sparse_pos1", bus.o_pos[1], 4);
    chk("sparse_pos2", bus.o_pos[2], 0);
    for (int g = 0; g < NG; g++)
      chk($sformatf("sparse_ptr[%0d]", g), bus.o_ptr[g], (g < 5) ? 2 : 3);

    build(2);
    encode(1'b0, 1'b0);
    chk("sat_ptr2", bus.o_ptr[2], 15);
    chk("sat_ptr3", bus.o_ptr[3], 16);
    chk("sat_ptr11", bus.o_ptr[11], 16);
    chk("sat_len", bus.o_length, 16);

`ifdef SWE_THRESH_PRUNE_EN
    thr = 3;
    bus.i_thresh = 7'd3;
    build(4);
    encode(1'b0, 1'b0);
    chk("thr_len", bus.o_length, 2);
    chk("thr_val0", bus.o_val[0], 253);
    chk("thr_val1", bus.o_val[1], 128);
    chk("thr_pos0", bus.o_pos[0], 1);
    chk("thr_pos1", bus.o_pos[1], 2);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/sparse_weight_encoder.md
# sparse_weight_encoder

Compresses a dense weight stream into the sparse pointer/row/channel format consumed by the address-to-register-file stage: per-group cumulative pointers, per-group row and channel tags, a packed nonzero value list with in-group positions, and a total length. It sits between the weight loader and the address generator. After `o_finish` pulses, its outputs feed directly onto the address generator's pointer, row, channel and length inputs.

## Interface
- `NGROUP`, default `` `IA_CHANNEL*3 ``: number of groups; group g carries row g%3 and channel g/3.
- `GLEN`, default 5: dense elements per group (positions 0..GLEN-1).
- `VAL_W`, default 8: weight width, two's complement.
- `CAP`, default `` `W_C_LENGTH ``: nonzero list capacity.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk` in, 1: clock.
- `i_rst_n` in, 1: asynchronous active-low reset.
- `i_start` in, 1: begin an encode; sampled only in IDLE.
- `i_valid` in, 1: `i_data` valid.
- `i_data` in, VAL_W: dense weight, group-major, position-minor order.
- `o_ready` out, 1: accepting data. A beat transfers when `i_valid & o_ready`.
- `o_ptr[0:NGROUP-1]` out, 11: cumulative nonzero count through group g, inclusive.
- `o_r[0:NGROUP-1]` out, 3: row tag, g%3 (constant).
- `o_k[0:NGROUP-1]` out, 5: channel tag, g/3 (constant).
- `o_val[0:CAP-1]` out, VAL_W: packed nonzero values.
- `o_pos[0:CAP-1]` out, 3: in-group position of each nonzero.
- `o_length` out, 11: total nonzeros stored.
- `o_overflow` out, 1: a nonzero was dropped because the list was full.
- `o_finish` out, 1: one-cycle pulse when the encode completes.

## Operation
- States:
  - IDLE: `o_ready`=0. `i_start` moves to RECV and clears the element counter, group counter, `o_length` and `o_overflow`.
  - RECV: `o_ready`=1. Moves to DONE on the beat that completes the last element of group NGROUP-1.
  - DONE: asserts `o_finish` for one cycle, then returns to IDLE.
- Each accepted beat:
  - If the value is nonzero and `o_length`<CAP, write `o_val[o_length]`=data and `o_pos[o_length]`=element index, then increment `o_length`.
  - If the value is nonzero and `o_length`==CAP, discard it and set `o_overflow` (sticky until the next start). `o_length` saturates at CAP.
  - The element index wraps from GLEN-1 to 0. On the wrap, `o_ptr[g]` is written with the updated length (including this beat) and g increments.
- A group with no nonzeros gets `o_ptr[g]` equal to `o_ptr[g-1]`, or 0 for g=0.
- `i_start` asserted in RECV or DONE is ignored.
- `i_valid` is ignored outside RECV.
- `o_val`/`o_pos` entries at or above `o_length` keep stale contents. The consumer reads only below `o_length`.
- Outputs hold their values in IDLE until the next `i_start`.

## Timing
- Reset value of every output is 0; state is IDLE. `o_r` and `o_k` are constants and ignore reset.
- Reset mid-encode aborts immediately. There is no partial-result guarantee.
- `i_start` at edge n: `o_ready`=1 from cycle n+1.
- Each beat updates `o_length`, `o_val`, `o_pos` and `o_ptr` one cycle after acceptance (registered).
- The final beat is accepted at edge m. `o_ready` falls and `o_finish`=1 during cycle m+1. All outputs are final and stable in that cycle.
- Minimum encode time is NGROUP*GLEN beats + 1 cycle. Stalls (`i_valid`=0) extend it without side effects.
- A beat is accepted at most once per cycle. There is no backpressure inside RECV.

## Configuration
- `SWE_THRESH_PRUNE_EN` defined:
  - Adds input port `i_thresh` (VAL_W-1 bits, unsigned), sampled on `i_start` and held for the encode.
  - A beat counts as zero when |data| < threshold. The most negative value has magnitude 2^(VAL_W-1).
  - Threshold 0 behaves as exact-zero detection.
- Undefined: no `i_thresh` port; only data==0 counts as zero.

## Structure
- Shared package `swe_pkg`: state enum (IDLE, RECV, DONE), `PTR_W`=11, `POS_W`=3, `R_W`=3, `K_W`=5.
- Widths shared with the address-to-RF stage live in `header.h` macros.
- One sub-module, `swe_nz_detect`: combinational zero/threshold test. The `SWE_THRESH_PRUNE_EN` logic is confined there.
- The counters, pointer accumulation and list writes stay in the top module.

## Test plan
All scenarios use NGROUP=12, GLEN=5, CAP=16, VAL_W=8.
- All-zero stream of 60 beats -> `o_length`=0, every `o_ptr`=0, `o_overflow`=0, `o_finish` one cycle after beat 60.
- Group 0 = {0,3,0,0,-2}, group 5 = {7,0,0,0,0}, rest zero -> `o_length`=3, `o_ptr[0..4]`=2, `o_ptr[5..11]`=3, `o_val`={3,-2,7}, `o_pos`={1,4,0}.
- All-nonzero stream (value 1) -> `o_length`=16, `o_overflow`=1, `o_ptr[2]`=15, `o_ptr[3..11]`=16.
- Random `i_valid` gaps plus `i_start` pulses during RECV -> results match the gapless run, and the encode is not restarted.
- `i_rst_n` dropped at beat 30, then a new encode of the second scenario's stream -> results identical to the second scenario, no residue from the aborted encode.
- With `SWE_THRESH_PRUNE_EN` and `i_thresh`=3: stream with group 0 = {2,-3,-128,0,1} -> `o_length`=2, `o_val`={-3,-128}, `o_pos`={1,2}.
